// File: rtl/writeback_stage.sv
// Final integer-core stage: picks one of the sx/dd/mx results for the register file,
// aligns load data, and funnels branch/miss rollbacks into one registered rollback port.
package defines_pkg;
  localparam int VECTOR_LANES     = 16;
  localparam int THREADS_PER_CORE = 4;
  typedef logic [31:0] scalar_t;
  typedef scalar_t [VECTOR_LANES-1:0] vector_t;
  typedef logic [4:0] register_idx_t;
  typedef logic [$clog2(THREADS_PER_CORE)-1:0] thread_idx_t;
  typedef logic [$clog2(VECTOR_LANES)-1:0] subcycle_t;
  typedef enum logic [2:0] {
    MEM_B, MEM_BX, MEM_S, MEM_SX, MEM_L, MEM_BLOCK, MEM_GATHER
  } memory_op_t;
  typedef struct packed {
    logic          has_dest;
    logic          dest_is_vector;
    register_idx_t dest_reg;
    logic          is_load;
    memory_op_t    memory_access_type;
  } decoded_instruction_t;
  typedef enum logic [1:0] {LANE_SCALAR, LANE_VECTOR, LANE_GATHER} lane_mode_t;
endpackage

// Per-lane value select: scalar goes to lane 0 only, gather to lane == subcycle only.
module wb_lane
  import defines_pkg::*;
#(
  parameter int LANE = 0
) (
  input  lane_mode_t mode,
  input  subcycle_t  subcycle,
  input  scalar_t    scalar_val,
  input  scalar_t    vec_word,
  output scalar_t    value
);
  always_comb begin
    value = '0;
    case (mode)
      LANE_SCALAR: if (LANE == 0) value = scalar_val;
      LANE_VECTOR: value = vec_word;
      LANE_GATHER: if (int'(subcycle) == LANE) value = scalar_val;
      default:     value = '0;
    endcase
  end
endmodule

module writeback_stage
  import defines_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sx_instruction_valid,
  input  decoded_instruction_t     sx_instruction,
  input  thread_idx_t              sx_thread_idx,
  input  vector_t                  sx_result,
  input  logic [VECTOR_LANES-1:0]  sx_mask_value,
  input  logic                     sx_rollback_en,
  input  logic [31:0]              sx_rollback_pc,
  input  logic                     dd_instruction_valid,
  input  decoded_instruction_t     dd_instruction,
  input  thread_idx_t              dd_thread_idx,
  input  subcycle_t                dd_subcycle,
  input  logic [511:0]             dd_load_data,
  input  logic [31:0]              dd_request_addr,
  input  logic [VECTOR_LANES-1:0]  dd_mask_value,
  input  logic                     dd_rollback_en,
  input  logic [31:0]              dd_rollback_pc,
  input  logic                     mx_instruction_valid,
  input  decoded_instruction_t     mx_instruction,
  input  thread_idx_t              mx_thread_idx,
  input  vector_t                  mx_result,
  input  logic [VECTOR_LANES-1:0]  mx_mask_value,
  output logic                     wb_writeback_en,
  output thread_idx_t              wb_writeback_thread_idx,
  output logic                     wb_writeback_is_vector,
  output register_idx_t            wb_writeback_reg,
  output vector_t                  wb_writeback_value,
  output logic [VECTOR_LANES-1:0]  wb_writeback_mask,
  output logic                     wb_rollback_en,
  output thread_idx_t              wb_rollback_thread_idx,
  output logic [31:0]              wb_rollback_pc,
  output logic                     wb_rollback_overflow
);
  logic        pend_valid, nxt_pend_valid;
  thread_idx_t pend_thread, nxt_pend_thread;
  logic [31:0] pend_pc, nxt_pend_pc;

  // Load alignment
  vector_t    line;
  logic [5:0] a;
  scalar_t    word_val, load_scalar;
  logic [7:0] byte_val;
  logic [15:0] short_val;

  assign line      = dd_load_data;
  assign a         = dd_request_addr[5:0];
  assign word_val  = line[a[5:2]];
  assign byte_val  = dd_load_data[{a, 3'b000} +: 8];
  assign short_val = dd_load_data[{a, 3'b000} +: 16];

  always_comb begin
    load_scalar = word_val;
    case (dd_instruction.memory_access_type)
      MEM_B:   load_scalar = {24'h0, byte_val};
      MEM_BX:  load_scalar = {{24{byte_val[7]}}, byte_val};
      MEM_S:   load_scalar = {16'h0, short_val};
      MEM_SX:  load_scalar = {{16{short_val[15]}}, short_val};
      default: load_scalar = word_val;
    endcase
  end

  // Eligibility: dd is older than sx, and anything for the pending thread is squashed
  logic dd_kills_sx, sx_ok, dd_ok, mx_ok;
  assign dd_kills_sx = dd_rollback_en && dd_thread_idx == sx_thread_idx;
  assign sx_ok = sx_instruction_valid && sx_instruction.has_dest && !dd_kills_sx
               && !(pend_valid && sx_thread_idx == pend_thread);
  assign dd_ok = dd_instruction_valid && dd_instruction.has_dest && !dd_rollback_en
               && !(pend_valid && dd_thread_idx == pend_thread);
  assign mx_ok = mx_instruction_valid && mx_instruction.has_dest;

  logic                    sel_en, sel_is_vec;
  thread_idx_t             sel_thread;
  register_idx_t           sel_reg;
  lane_mode_t              sel_mode;
  scalar_t                 sel_scalar;
  vector_t                 sel_vec, sel_value;
  logic [VECTOR_LANES-1:0] sel_mask;

  always_comb begin
    sel_en = 1'b0; sel_is_vec = 1'b0; sel_thread = '0; sel_reg = '0;
    sel_mode = LANE_SCALAR; sel_scalar = '0; sel_vec = '0; sel_mask = '0;
    if (mx_ok) begin
      sel_en = 1'b1; sel_thread = mx_thread_idx; sel_reg = mx_instruction.dest_reg;
      sel_is_vec = mx_instruction.dest_is_vector;
      sel_mode = sel_is_vec ? LANE_VECTOR : LANE_SCALAR;
      sel_vec = mx_result; sel_scalar = mx_result[0]; sel_mask = mx_mask_value;
    end else if (dd_ok) begin
      sel_en = 1'b1; sel_thread = dd_thread_idx; sel_reg = dd_instruction.dest_reg;
      sel_is_vec = dd_instruction.dest_is_vector;
      sel_mask = dd_mask_value; sel_scalar = word_val;
      if (dd_instruction.is_load) begin
        case (dd_instruction.memory_access_type)
          MEM_BLOCK: begin sel_mode = LANE_VECTOR; sel_vec = line; end
          MEM_GATHER: begin
            sel_mode = LANE_GATHER;
            sel_mask = dd_mask_value & ({{(VECTOR_LANES-1){1'b0}}, 1'b1} << dd_subcycle);
          end
          default: sel_scalar = load_scalar;
        endcase
      end
    end else if (sx_ok) begin
      sel_en = 1'b1; sel_thread = sx_thread_idx; sel_reg = sx_instruction.dest_reg;
      sel_is_vec = sx_instruction.dest_is_vector;
      sel_mode = sel_is_vec ? LANE_VECTOR : LANE_SCALAR;
      sel_vec = sx_result; sel_scalar = sx_result[0]; sel_mask = sx_mask_value;
    end
  end

  for (genvar i = 0; i < VECTOR_LANES; i++) begin : g_lane
    wb_lane #(.LANE(i)) u_lane (
      .mode(sel_mode), .subcycle(dd_subcycle), .scalar_val(sel_scalar),
      .vec_word(sel_vec[i]), .value(sel_value[i])
    );
  end

  // Rollback arbitration; a valid pending entry always emits the cycle after capture
  logic        rb_en, sx_rb_live, set_ovf;
  thread_idx_t rb_thread;
  logic [31:0] rb_pc;
  assign sx_rb_live = sx_rollback_en && !dd_kills_sx;

  always_comb begin
    rb_en = 1'b0; rb_thread = '0; rb_pc = '0; set_ovf = 1'b0;
    nxt_pend_valid = 1'b0; nxt_pend_thread = pend_thread; nxt_pend_pc = pend_pc;
    if (pend_valid) begin
      rb_en = 1'b1; rb_thread = pend_thread; rb_pc = pend_pc;
      if (dd_rollback_en) begin
        nxt_pend_valid = 1'b1; nxt_pend_thread = dd_thread_idx; nxt_pend_pc = dd_rollback_pc;
        set_ovf = sx_rb_live;
      end else if (sx_rb_live) begin
        nxt_pend_valid = 1'b1; nxt_pend_thread = sx_thread_idx; nxt_pend_pc = sx_rollback_pc;
      end
    end else if (dd_rollback_en) begin
      rb_en = 1'b1; rb_thread = dd_thread_idx; rb_pc = dd_rollback_pc;
      if (sx_rb_live) begin
        nxt_pend_valid = 1'b1; nxt_pend_thread = sx_thread_idx; nxt_pend_pc = sx_rollback_pc;
      end
    end else if (sx_rb_live) begin
      rb_en = 1'b1; rb_thread = sx_thread_idx; rb_pc = sx_rollback_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid <= 1'b0; pend_thread <= '0; pend_pc <= '0;
      wb_writeback_en <= 1'b0; wb_writeback_thread_idx <= '0; wb_writeback_is_vector <= 1'b0;
      wb_writeback_reg <= '0; wb_writeback_value <= '0; wb_writeback_mask <= '0;
      wb_rollback_en <= 1'b0; wb_rollback_thread_idx <= '0; wb_rollback_pc <= '0;
      wb_rollback_overflow <= 1'b0;
    end else begin
      pend_valid <= nxt_pend_valid; pend_thread <= nxt_pend_thread; pend_pc <= nxt_pend_pc;
      wb_writeback_en <= sel_en; wb_writeback_thread_idx <= sel_thread;
      wb_writeback_is_vector <= sel_is_vec; wb_writeback_reg <= sel_reg;
      wb_writeback_value <= sel_value; wb_writeback_mask <= sel_mask;
      wb_rollback_en <= rb_en; wb_rollback_thread_idx <= rb_thread; wb_rollback_pc <= rb_pc;
      if (set_ovf) wb_rollback_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: selection, load alignment, rollback arbitration.
module tb_writeback_stage;
  import defines_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sx_instruction_valid, dd_instruction_valid, mx_instruction_valid;
  decoded_instruction_t sx_instruction, dd_instruction, mx_instruction;
  thread_idx_t sx_thread_idx, dd_thread_idx, mx_thread_idx;
  vector_t sx_result, mx_result;
  logic [VECTOR_LANES-1:0] sx_mask_value, dd_mask_value, mx_mask_value;
  logic sx_rollback_en, dd_rollback_en;
  logic [31:0] sx_rollback_pc, dd_rollback_pc, dd_request_addr;
  subcycle_t dd_subcycle;
  logic [511:0] dd_load_data;
  logic wb_writeback_en, wb_writeback_is_vector, wb_rollback_en, wb_rollback_overflow;
  thread_idx_t wb_writeback_thread_idx, wb_rollback_thread_idx;
  register_idx_t wb_writeback_reg;
  vector_t wb_writeback_value;
  logic [VECTOR_LANES-1:0] wb_writeback_mask;
  logic [31:0] wb_rollback_pc;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk(clk), .reset(reset),
    .sx_instruction_valid(sx_instruction_valid), .sx_instruction(sx_instruction),
    .sx_thread_idx(sx_thread_idx), .sx_result(sx_result), .sx_mask_value(sx_mask_value),
    .sx_rollback_en(sx_rollback_en), .sx_rollback_pc(sx_rollback_pc),
    .dd_instruction_valid(dd_instruction_valid), .dd_instruction(dd_instruction),
    .dd_thread_idx(dd_thread_idx), .dd_subcycle(dd_subcycle), .dd_load_data(dd_load_data),
    .dd_request_addr(dd_request_addr), .dd_mask_value(dd_mask_value),
    .dd_rollback_en(dd_rollback_en), .dd_rollback_pc(dd_rollback_pc),
    .mx_instruction_valid(mx_instruction_valid), .mx_instruction(mx_instruction),
    .mx_thread_idx(mx_thread_idx), .mx_result(mx_result), .mx_mask_value(mx_mask_value),
    .wb_writeback_en(wb_writeback_en), .wb_writeback_thread_idx(wb_writeback_thread_idx),
    .wb_writeback_is_vector(wb_writeback_is_vector), .wb_writeback_reg(wb_writeback_reg),
    .wb_writeback_value(wb_writeback_value), .wb_writeback_mask(wb_writeback_mask),
    .wb_rollback_en(wb_rollback_en), .wb_rollback_thread_idx(wb_rollback_thread_idx),
    .wb_rollback_pc(wb_rollback_pc), .wb_rollback_overflow(wb_rollback_overflow)
  );

  function automatic decoded_instruction_t mk(input logic has_dest, input logic is_vec,
      input register_idx_t rd, input logic is_load, input memory_op_t mt);
    decoded_instruction_t d;
    d.has_dest = has_dest; d.dest_is_vector = is_vec; d.dest_reg = rd;
    d.is_load = is_load; d.memory_access_type = mt;
    return d;
  endfunction

  task automatic idle();
    sx_instruction_valid = 0; dd_instruction_valid = 0; mx_instruction_valid = 0;
    sx_instruction = '0; dd_instruction = '0; mx_instruction = '0;
    sx_thread_idx = '0; dd_thread_idx = '0; mx_thread_idx = '0;
    sx_result = '0; mx_result = '0; sx_mask_value = '0; dd_mask_value = '0; mx_mask_value = '0;
    sx_rollback_en = 0; dd_rollback_en = 0; sx_rollback_pc = '0; dd_rollback_pc = '0;
    dd_request_addr = '0; dd_subcycle = '0; dd_load_data = '0;
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); reset = 1; tick(); tick(); reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (wb_writeback_en !== 1'b0) begin bad++; $display("FAIL reset_wb_en got=%0b want=0", wb_writeback_en); end
    total++; if (wb_writeback_value !== '0) begin bad++; $display("FAIL reset_wb_value got=%h want=0", wb_writeback_value); end
    total++; if (wb_rollback_en !== 1'b0 || wb_rollback_pc !== 32'h0) begin bad++; $display("FAIL reset_rb got=%0b/%h want=0/0", wb_rollback_en, wb_rollback_pc); end
    total++; if (wb_rollback_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b want=0", wb_rollback_overflow); end
  endtask

  task automatic test_sx_scalar();
    vector_t exp_v;
    idle();
    sx_instruction_valid = 1; sx_instruction = mk(1, 0, 5'd5, 0, MEM_L); sx_thread_idx = 2'd1;
    sx_result = '0; sx_result[0] = 32'h1234; sx_result[3] = 32'h5555; sx_mask_value = 16'hFFFF;
    tick(); idle();
    exp_v = '0; exp_v[0] = 32'h1234;
    total++; if (wb_writeback_en !== 1 || wb_writeback_reg !== 5'd5 || wb_writeback_thread_idx !== 2'd1 || wb_writeback_is_vector !== 0)
      begin bad++; $display("FAIL sx_ctl got en=%0b reg=%0d thr=%0d vec=%0b want 1/5/1/0", wb_writeback_en, wb_writeback_reg, wb_writeback_thread_idx, wb_writeback_is_vector); end
    total++; if (wb_writeback_value !== exp_v) begin bad++; $display("FAIL sx_value got=%h want=%h", wb_writeback_value, exp_v); end
    tick();
    total++; if (wb_writeback_en !== 0) begin bad++; $display("FAIL sx_one_cycle got=%0b want=0", wb_writeback_en); end
  endtask

  task automatic test_loads();
    logic [511:0] ln;
    idle();
    ln = '0; ln[31:24] = 8'h80; ln[55:48] = 8'h34; ln[63:56] = 8'h92; ln[95:64] = 32'hCAFEF00D;
    dd_instruction_valid = 1; dd_thread_idx = 2'd0; dd_load_data = ln; dd_mask_value = 16'hFFFF;
    dd_request_addr = 32'h1003; dd_instruction = mk(1, 0, 5'd7, 1, MEM_BX);
    tick();
    total++; if (wb_writeback_value[0] !== 32'hFFFFFF80) begin bad++; $display("FAIL load_bx got=%h want=ffffff80", wb_writeback_value[0]); end
    dd_instruction = mk(1, 0, 5'd7, 1, MEM_B);
    tick();
    total++; if (wb_writeback_value[0] !== 32'h00000080) begin bad++; $display("FAIL load_b got=%h want=00000080", wb_writeback_value[0]); end
    dd_request_addr = 32'h1006; dd_instruction = mk(1, 0, 5'd7, 1, MEM_SX);
    tick();
    total++; if (wb_writeback_value[0] !== 32'hFFFF9234) begin bad++; $display("FAIL load_sx got=%h want=ffff9234", wb_writeback_value[0]); end
    dd_request_addr = 32'h1008; dd_instruction = mk(1, 0, 5'd7, 1, MEM_L);
    tick();
    total++; if (wb_writeback_value[0] !== 32'hCAFEF00D || wb_writeback_value[1] !== 32'h0) begin bad++; $display("FAIL load_word got=%h want=cafef00d", wb_writeback_value[0]); end
    dd_instruction = mk(1, 0, 5'd9, 0, MEM_L);
    tick();
    total++; if (wb_writeback_value[0] !== 32'hCAFEF00D || wb_writeback_reg !== 5'd9) begin bad++; $display("FAIL store_status got=%h/%0d want=cafef00d/9", wb_writeback_value[0], wb_writeback_reg); end
    for (int i = 0; i < 16; i++) ln[32*i +: 32] = 32'h10000000 + i;
    dd_load_data = ln; dd_mask_value = 16'hA5A5; dd_instruction = mk(1, 1, 5'd3, 1, MEM_BLOCK);
    tick(); idle();
    total++; if (wb_writeback_value !== vector_t'(ln) || wb_writeback_mask !== 16'hA5A5 || wb_writeback_is_vector !== 1)
      begin bad++; $display("FAIL load_block got=%h mask=%h want mask=a5a5", wb_writeback_value, wb_writeback_mask); end
  endtask

  task automatic test_gather();
    vector_t exp_v;
    idle();
    dd_instruction_valid = 1; dd_thread_idx = 2'd2; dd_instruction = mk(1, 1, 5'd4, 1, MEM_GATHER);
    dd_subcycle = 4'd7; dd_request_addr = 32'h2008; dd_mask_value = 16'hFFFF;
    dd_load_data = '0; dd_load_data[95:64] = 32'hDEADBEEF;
    tick(); idle();
    exp_v = '0; exp_v[7] = 32'hDEADBEEF;
    total++; if (wb_writeback_value !== exp_v) begin bad++; $display("FAIL gather_value got=%h want=%h", wb_writeback_value, exp_v); end
    total++; if (wb_writeback_mask !== 16'h0080) begin bad++; $display("FAIL gather_mask got=%h want=0080", wb_writeback_mask); end
  endtask

  task automatic test_priority();
    idle();
    mx_instruction_valid = 1; mx_instruction = mk(1, 0, 5'd10, 0, MEM_L); mx_thread_idx = 2'd3; mx_result[0] = 32'hAAAA;
    sx_instruction_valid = 1; sx_instruction = mk(1, 0, 5'd11, 0, MEM_L); sx_thread_idx = 2'd1; sx_result[0] = 32'hBBBB;
    tick();
    total++; if (wb_writeback_reg !== 5'd10 || wb_writeback_value[0] !== 32'hAAAA) begin bad++; $display("FAIL prio_mx got reg=%0d val=%h want 10/aaaa", wb_writeback_reg, wb_writeback_value[0]); end
    mx_instruction_valid = 0; sx_instruction = mk(0, 0, 5'd11, 0, MEM_L);
    tick(); idle();
    total++; if (wb_writeback_en !== 0) begin bad++; $display("FAIL no_dest got=%0b want=0", wb_writeback_en); end
  endtask

  task automatic test_same_thread();
    idle();
    dd_instruction_valid = 1; dd_instruction = mk(1, 0, 5'd2, 1, MEM_L); dd_thread_idx = 2'd2;
    dd_rollback_en = 1; dd_rollback_pc = 32'h400;
    sx_instruction_valid = 1; sx_instruction = mk(1, 0, 5'd6, 0, MEM_L); sx_thread_idx = 2'd2; sx_result[0] = 32'h77;
    tick();
    total++; if (wb_rollback_en !== 1 || wb_rollback_thread_idx !== 2'd2 || wb_rollback_pc !== 32'h400)
      begin bad++; $display("FAIL same_rb got=%0b/%0d/%h want 1/2/400", wb_rollback_en, wb_rollback_thread_idx, wb_rollback_pc); end
    total++; if (wb_writeback_en !== 0) begin bad++; $display("FAIL same_wb got=%0b want=0", wb_writeback_en); end
    sx_thread_idx = 2'd3;
    tick(); idle();
    total++; if (wb_writeback_en !== 1 || wb_writeback_thread_idx !== 2'd3 || wb_rollback_thread_idx !== 2'd2)
      begin bad++; $display("FAIL other_thread got en=%0b thr=%0d rbthr=%0d want 1/3/2", wb_writeback_en, wb_writeback_thread_idx, wb_rollback_thread_idx); end
    tick();
    total++; if (wb_rollback_en !== 0) begin bad++; $display("FAIL same_no_pending got=%0b want=0", wb_rollback_en); end
  endtask

  task automatic test_diff_thread();
    idle();
    dd_instruction_valid = 1; dd_thread_idx = 2'd0; dd_rollback_en = 1; dd_rollback_pc = 32'h100;
    sx_instruction_valid = 1; sx_instruction = mk(1, 0, 5'd31, 0, MEM_L); sx_thread_idx = 2'd1;
    sx_rollback_en = 1; sx_rollback_pc = 32'h200; sx_result[0] = 32'h44;
    tick(); idle();
    sx_instruction_valid = 1; sx_instruction = mk(1, 0, 5'd8, 0, MEM_L); sx_thread_idx = 2'd1; sx_result[0] = 32'h99;
    total++; if (wb_rollback_en !== 1 || wb_rollback_thread_idx !== 2'd0 || wb_rollback_pc !== 32'h100)
      begin bad++; $display("FAIL diff_n1 got=%0b/%0d/%h want 1/0/100", wb_rollback_en, wb_rollback_thread_idx, wb_rollback_pc); end
    total++; if (wb_writeback_en !== 1 || wb_writeback_reg !== 5'd31 || wb_writeback_value[0] !== 32'h44)
      begin bad++; $display("FAIL link_write got en=%0b reg=%0d val=%h want 1/31/44", wb_writeback_en, wb_writeback_reg, wb_writeback_value[0]); end
    tick(); idle();
    total++; if (wb_rollback_en !== 1 || wb_rollback_thread_idx !== 2'd1 || wb_rollback_pc !== 32'h200)
      begin bad++; $display("FAIL diff_n2 got=%0b/%0d/%h want 1/1/200", wb_rollback_en, wb_rollback_thread_idx, wb_rollback_pc); end
    total++; if (wb_writeback_en !== 0) begin bad++; $display("FAIL pend_suppress got=%0b want=0", wb_writeback_en); end
    tick();
    total++; if (wb_rollback_en !== 0 || wb_rollback_overflow !== 0) begin bad++; $display("FAIL diff_n3 got=%0b ovf=%0b want 0/0", wb_rollback_en, wb_rollback_overflow); end
  endtask

  task automatic test_overflow();
    idle();
    dd_thread_idx = 2'd0; dd_rollback_en = 1; dd_rollback_pc = 32'h100;
    sx_thread_idx = 2'd1; sx_rollback_en = 1; sx_rollback_pc = 32'h200;
    tick();
    dd_thread_idx = 2'd2; dd_rollback_pc = 32'h300;
    sx_thread_idx = 2'd3; sx_rollback_pc = 32'h500;
    tick(); idle();
    total++; if (wb_rollback_thread_idx !== 2'd1 || wb_rollback_overflow !== 1) begin bad++; $display("FAIL ovf_set got thr=%0d ovf=%0b want 1/1", wb_rollback_thread_idx, wb_rollback_overflow); end
    tick();
    total++; if (wb_rollback_en !== 1 || wb_rollback_thread_idx !== 2'd2 || wb_rollback_pc !== 32'h300)
      begin bad++; $display("FAIL ovf_dd_kept got=%0b/%0d/%h want 1/2/300", wb_rollback_en, wb_rollback_thread_idx, wb_rollback_pc); end
    tick(); tick();
    total++; if (wb_rollback_en !== 0 || wb_rollback_overflow !== 1) begin bad++; $display("FAIL ovf_sticky got en=%0b ovf=%0b want 0/1", wb_rollback_en, wb_rollback_overflow); end
    do_reset();
    total++; if (wb_rollback_overflow !== 0) begin bad++; $display("FAIL ovf_reset got=%0b want=0", wb_rollback_overflow); end
  endtask

  task automatic test_reset_mid();
    idle();
    dd_thread_idx = 2'd0; dd_rollback_en = 1; dd_rollback_pc = 32'h100;
    sx_thread_idx = 2'd1; sx_rollback_en = 1; sx_rollback_pc = 32'h200;
    tick(); idle();
    reset = 1; #2; reset = 0;
    tick();
    total++; if (wb_rollback_en !== 0) begin bad++; $display("FAIL reset_drops_pending got=%0b want=0", wb_rollback_en); end
  endtask

  initial begin
    test_reset();
    test_sx_scalar();
    test_loads();
    test_gather();
    test_priority();
    test_same_thread();
    test_diff_thread();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final integer-core pipeline stage. Each cycle it selects one result from three execution pipelines: single-cycle integer (sx), memory/data-cache (dd) and multi-cycle (mx). It aligns and extends load data, then drives the register-file write port. It also arbitrates branch and cache-miss rollbacks into the single rollback port consumed by the thread-select, operand-fetch and execute stages.

## Interface
- Parameters: none; widths come from `VECTOR_LANES` (16), `THREADS_PER_CORE`, `scalar_t` (32 b), `vector_t`, `register_idx_t` (5 b), `decoded_instruction_t`.
- Clocking: one clock; reset is asynchronous and active-high.
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- sx_instruction_valid / sx_instruction / sx_thread_idx  in  1 / decoded_instruction_t / thread_idx_t  single-cycle pipe result
- sx_result  in  vector_t  ALU result
- sx_mask_value  in  VECTOR_LANES  lane mask
- sx_rollback_en / sx_rollback_pc  in  1 / 32  taken branch and its target
- dd_instruction_valid / dd_instruction / dd_thread_idx / dd_subcycle  in  1 / decoded_instruction_t / thread_idx_t / subcycle_t  memory pipe
- dd_load_data  in  512  cache line; byte b is bits [8b+7:8b]
- dd_request_addr  in  32  access address
- dd_mask_value  in  VECTOR_LANES  lane mask
- dd_rollback_en / dd_rollback_pc  in  1 / 32  cache miss; replay PC
- mx_instruction_valid / mx_instruction / mx_thread_idx / mx_result / mx_mask_value  in  as sx  multi-cycle pipe result
- wb_writeback_en / wb_writeback_thread_idx / wb_writeback_is_vector / wb_writeback_reg  out  1 / thread_idx_t / 1 / 5  register write control
- wb_writeback_value / wb_writeback_mask  out  vector_t / VECTOR_LANES  write data and lane enables
- wb_rollback_en / wb_rollback_thread_idx / wb_rollback_pc  out  1 / thread_idx_t / 32  squash and redirect
- wb_rollback_overflow  out  1  sticky error: a rollback was dropped

## Operation
- Writeback selection:
  - A source is eligible when valid && instruction.has_dest && not suppressed.
  - Priority mx > dd > sx. Issue normally guarantees one-hot; when it does not, lower-priority sources are dropped.
- Suppression:
  - A dd result with dd_rollback_en is suppressed.
  - An sx result is suppressed if a dd rollback for the same thread arrives that cycle (dd is older).
  - sx and dd results whose thread equals the pending-rollback thread are suppressed.
  - mx is never suppressed.
  - An sx result carrying its own sx_rollback_en still writes (call link register).
- Scalar writeback: value lane 0 = result, other lanes 0. wb_writeback_is_vector = dest_is_vector.
- Load alignment (dd, is_load), by memory_access_type; a = dd_request_addr[5:0]:
  - Byte: zero or sign extend byte a.
  - Short: zero or sign extend bytes a..a+1; a[0]=0 is guaranteed.
  - Word: word a[5:2].
  - Block: lane i = word i; mask = dd_mask_value.
  - Gather: lane dd_subcycle = word a[5:2]; mask = dd_mask_value & (1 << dd_subcycle).
- Non-load dd instructions with has_dest (store-conditional status) write sx-style scalar values taken from word a[5:2].
- Rollback arbitration, priority pending > dd > sx:
  - If dd and sx roll back the same thread in one cycle, dd wins and sx is discarded.
  - Different threads: the winner is emitted. A new loser enters the one-entry pending register (thread, pc) if pending is free or being emitted this cycle.
  - Pending emitting while both new dd and sx rollbacks arrive for different threads: dd is stored, sx is dropped, and wb_rollback_overflow sets until reset.

## Timing
- All outputs registered; latency exactly 1 cycle from inputs to wb_* outputs.
- wb_writeback_en and wb_rollback_en are each high for one cycle per event.
- A pending rollback emits on the cycle after it is captured.
- Writeback and rollback are independent and may assert together in the same cycle.
- Reset: every output 0, pending invalid, overflow cleared. Reset mid-operation discards the pending entry.

## Test plan
- sx scalar add: thread 1, r5, sx_result lane0 = 0x1234 -> next cycle en=1, reg=5, value lane0 = 0x1234, other lanes 0, is_vector=0.
- Signed byte load: addr 0x1003, byte 3 = 0x80 -> value lane0 = 0xFFFFFF80; unsigned variant -> 0x00000080.
- Gather: dd_subcycle = 7, addr word 0x2 = 0xDEADBEEF, mask 0xFFFF -> lane7 = 0xDEADBEEF, mask 0x0080.
- Same-thread collision: dd rollback thread 2, pc 0x400, plus sx result thread 2 -> rollback (2, 0x400) and no writeback. With the sx result on thread 3 instead -> thread-3 write occurs.
- Different-thread rollbacks: dd thread 0 and sx thread 1 in cycle N -> rollback thread 0 at N+1, thread 1 at N+2. An sx result for thread 1 at N+1 is suppressed.
- Overflow: pending valid, plus new dd and sx rollbacks on two further threads -> wb_rollback_overflow = 1 and stays set until reset.
